// File: rtl/io_pkg.sv
// Shared types and constants for the IO slot fabric and its peripherals.
package io_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StWait,
      StResp
   } io_fab_state_t;

   localparam int unsigned IO_DATA_W     = 32;
   localparam int unsigned IO_REG_ADDR_W = 5;

   localparam int unsigned IO_SLOT_UART   = 0;
   localparam int unsigned IO_SLOT_SPI    = 1;
   localparam int unsigned IO_SLOT_MMUL   = 2;
   localparam int unsigned IO_SLOT_CORDIC = 3;

endpackage

// File: rtl/io_slot_decoder.sv
// Combinational slot decoder: slot index to one-hot select plus populated flag.
module io_slot_decoder
   import io_pkg::*;
#(
   parameter int unsigned          NUM_SLOTS = 16,
   parameter logic [NUM_SLOTS-1:0] SLOT_MASK = {{(NUM_SLOTS-1){1'b0}}, 1'b1},
   localparam int unsigned         SlotW     = $clog2(NUM_SLOTS)
) (
   input  logic [SlotW-1:0]     slot_idx_i,
   output logic [NUM_SLOTS-1:0] slot_onehot_o,
   output logic                 populated_o
);

   always_comb begin
      slot_onehot_o             = '0;
      slot_onehot_o[slot_idx_i] = 1'b1;
   end

   assign populated_o = SLOT_MASK[slot_idx_i];

endmodule

// File: rtl/io_slot_fabric.sv
// Bus fabric decoding CPU IO accesses onto NUM_SLOTS peripheral slots with ready handshake.
// Define IO_FABRIC_TIMEOUT_EN to add the WAIT-state timeout watchdog.
module io_slot_fabric
   import io_pkg::*;
#(
   parameter int unsigned          NUM_SLOTS      = 16,
   parameter int unsigned          REG_ADDR_W     = IO_REG_ADDR_W,
   parameter logic [NUM_SLOTS-1:0] SLOT_MASK      = {{(NUM_SLOTS-1){1'b0}}, 1'b1},
   parameter int unsigned          TIMEOUT_CYCLES = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           bus_cs,
   input  logic                           bus_wr,
   input  logic                           bus_rd,
   input  logic [31:0]                    bus_addr,
   input  logic [31:0]                    bus_wr_data,
   output logic [31:0]                    bus_rd_data,
   output logic                           bus_ack,
   output logic                           bus_err,
   output logic [NUM_SLOTS-1:0]           slot_cs,
   output logic [NUM_SLOTS-1:0]           slot_rd,
   output logic [NUM_SLOTS-1:0]           slot_wr,
   output logic [REG_ADDR_W-1:0]          slot_reg_addr,
   output logic [31:0]                    slot_wr_data,
   input  logic [NUM_SLOTS*IO_DATA_W-1:0] slot_rd_data,
   input  logic [NUM_SLOTS-1:0]           slot_ready
);

   localparam int unsigned SlotW  = $clog2(NUM_SLOTS);
   localparam int unsigned SlotLo = REG_ADDR_W + 2;

   io_fab_state_t state_q, state_d;

   logic [SlotW-1:0]      slot_q, slot_d;
   logic                  is_wr_q, is_wr_d;
   logic                  bus_ack_q, bus_ack_d;
   logic                  bus_err_q, bus_err_d;
   logic [31:0]           bus_rd_data_q, bus_rd_data_d;
   logic [NUM_SLOTS-1:0]  slot_cs_q, slot_cs_d;
   logic [NUM_SLOTS-1:0]  slot_rd_q, slot_rd_d;
   logic [NUM_SLOTS-1:0]  slot_wr_q, slot_wr_d;
   logic [REG_ADDR_W-1:0] slot_reg_addr_q, slot_reg_addr_d;
   logic [31:0]           slot_wr_data_q, slot_wr_data_d;

   logic [SlotW-1:0]     req_slot;
   logic [NUM_SLOTS-1:0] req_onehot;
   logic                 req_populated;
   logic                 req_valid;
   logic                 sel_ready;
   logic [31:0]          sel_rdata;
   logic                 unused_addr;

   assign req_slot    = bus_addr[SlotLo +: SlotW];
   assign req_valid   = bus_cs & (bus_rd | bus_wr);
   assign sel_ready   = slot_ready[slot_q];
   assign sel_rdata   = slot_rd_data[int'(slot_q)*IO_DATA_W +: IO_DATA_W];
   assign unused_addr = ^{bus_addr[31:SlotLo+SlotW], bus_addr[1:0]};

   io_slot_decoder #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_MASK (SLOT_MASK)
   ) u_decoder (
      .slot_idx_i    (req_slot),
      .slot_onehot_o (req_onehot),
      .populated_o   (req_populated)
   );

`ifdef IO_FABRIC_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

   // Every output register is loaded with its value for the state being entered.
   always_comb begin
      state_d         = state_q;
      slot_d          = slot_q;
      is_wr_d         = is_wr_q;
      bus_ack_d       = 1'b0;
      bus_err_d       = 1'b0;
      bus_rd_data_d   = '0;
      slot_cs_d       = '0;
      slot_rd_d       = '0;
      slot_wr_d       = '0;
      slot_reg_addr_d = '0;
      slot_wr_data_d  = '0;
`ifdef IO_FABRIC_TIMEOUT_EN
      wait_cnt_d      = wait_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               slot_d  = req_slot;
               is_wr_d = bus_wr;
               if ((bus_rd && bus_wr) || !req_populated) begin
                  state_d   = StResp;
                  bus_ack_d = 1'b1;
                  bus_err_d = 1'b1;
               end else begin
                  state_d         = StAccess;
                  slot_cs_d       = req_onehot;
                  slot_rd_d       = bus_rd ? req_onehot : '0;
                  slot_wr_d       = bus_wr ? req_onehot : '0;
                  slot_reg_addr_d = bus_addr[REG_ADDR_W+1:2];
                  slot_wr_data_d  = bus_wr_data;
`ifdef IO_FABRIC_TIMEOUT_EN
                  wait_cnt_d      = '0;
`endif
               end
            end
         end
         StAccess, StWait: begin
            if (sel_ready) begin
               state_d       = StResp;
               bus_ack_d     = 1'b1;
               bus_rd_data_d = is_wr_q ? '0 : sel_rdata;
`ifdef IO_FABRIC_TIMEOUT_EN
            end else if (state_q == StWait && wait_cnt_q == TimeoutLast) begin
               state_d   = StResp;
               bus_ack_d = 1'b1;
               bus_err_d = 1'b1;
`endif
            end else begin
               state_d         = StWait;
               slot_cs_d       = slot_cs_q;
               slot_reg_addr_d = slot_reg_addr_q;
               slot_wr_data_d  = slot_wr_data_q;
`ifdef IO_FABRIC_TIMEOUT_EN
               if (state_q == StWait) wait_cnt_d = wait_cnt_q + 16'd1;
`endif
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         slot_q          <= '0;
         is_wr_q         <= 1'b0;
         bus_ack_q       <= 1'b0;
         bus_err_q       <= 1'b0;
         bus_rd_data_q   <= '0;
         slot_cs_q       <= '0;
         slot_rd_q       <= '0;
         slot_wr_q       <= '0;
         slot_reg_addr_q <= '0;
         slot_wr_data_q  <= '0;
`ifdef IO_FABRIC_TIMEOUT_EN
         wait_cnt_q      <= '0;
`endif
      end else begin
         state_q         <= state_d;
         slot_q          <= slot_d;
         is_wr_q         <= is_wr_d;
         bus_ack_q       <= bus_ack_d;
         bus_err_q       <= bus_err_d;
         bus_rd_data_q   <= bus_rd_data_d;
         slot_cs_q       <= slot_cs_d;
         slot_rd_q       <= slot_rd_d;
         slot_wr_q       <= slot_wr_d;
         slot_reg_addr_q <= slot_reg_addr_d;
         slot_wr_data_q  <= slot_wr_data_d;
`ifdef IO_FABRIC_TIMEOUT_EN
         wait_cnt_q      <= wait_cnt_d;
`endif
      end
   end

   assign bus_ack       = bus_ack_q;
   assign bus_err       = bus_err_q;
   assign bus_rd_data   = bus_rd_data_q;
   assign slot_cs       = slot_cs_q;
   assign slot_rd       = slot_rd_q;
   assign slot_wr       = slot_wr_q;
   assign slot_reg_addr = slot_reg_addr_q;
   assign slot_wr_data  = slot_wr_data_q;

endmodule

// File: tb/tb_io_slot_fabric.sv
// Scoreboard bench for io_slot_fabric; slot 0 is a behavioural slot with programmable ready delay.
module tb_io_slot_fabric;

   localparam int unsigned NSlots = 16;
   localparam int unsigned RegW   = 5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 bus_cs, bus_wr, bus_rd;
   logic [31:0]          bus_addr, bus_wr_data, bus_rd_data;
   logic                 bus_ack, bus_err;
   logic [NSlots-1:0]    slot_cs, slot_rd, slot_wr, slot_ready;
   logic [RegW-1:0]      slot_reg_addr;
   logic [31:0]          slot_wr_data;
   logic [NSlots*32-1:0] slot_rd_data;

   io_slot_fabric #(
      .NUM_SLOTS      (NSlots),
      .REG_ADDR_W     (RegW),
      .SLOT_MASK      (16'h0001),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus_cs        (bus_cs),
      .bus_wr        (bus_wr),
      .bus_rd        (bus_rd),
      .bus_addr      (bus_addr),
      .bus_wr_data   (bus_wr_data),
      .bus_rd_data   (bus_rd_data),
      .bus_ack       (bus_ack),
      .bus_err       (bus_err),
      .slot_cs       (slot_cs),
      .slot_rd       (slot_rd),
      .slot_wr       (slot_wr),
      .slot_reg_addr (slot_reg_addr),
      .slot_wr_data  (slot_wr_data),
      .slot_rd_data  (slot_rd_data),
      .slot_ready    (slot_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          age = 0;
   int          rdy_delay = 0;
   logic        rdy_en = 1'b1;
   logic [31:0] slot0_data = '0;

   int          cs_cycles, rd_cycles, wr_cycles, strobe_cyc;
   logic [31:0] strobe_addr, strobe_wdata, strobe_vec;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      age <= slot_cs[0] ? age + 1 : 0;
   end

   // Non-selected slots always claim ready so a mis-selected ready would complete early.
   assign slot_ready = {{(NSlots-1){1'b1}}, rdy_en && slot_cs[0] && (age == rdy_delay)};

   always_comb begin
      for (int i = 0; i < NSlots; i++)
         slot_rd_data[i*32 +: 32] = (i == 0) ? slot0_data : (32'hBAD0_0000 | 32'(i));
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus_ack) begin
            if (sb.size() == 0) begin
               check_val("spurious_ack", 32'(bus_ack), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_val("ack_cycle", 32'(cyc), 32'(e.cyc));
               check_val("bus_err", 32'(bus_err), 32'(e.err));
               check_val("bus_rd_data", bus_rd_data, e.data);
            end
         end
         if (slot_cs != '0) check_val("cs_onehot", 32'($onehot(slot_cs)), 32'd1);
         if ((slot_rd | slot_wr) != '0) begin
            check_val("strobe_in_cs", 32'((slot_rd | slot_wr) & ~slot_cs), 32'd0);
            strobe_cyc   = cyc;
            strobe_addr  = 32'(slot_reg_addr);
            strobe_wdata = slot_wr_data;
            strobe_vec   = 32'(slot_rd | slot_wr);
         end
         if (slot_cs[0]) cs_cycles++;
         if (slot_rd != '0) rd_cycles++;
         if (slot_wr != '0) wr_cycles++;
      end
   end

   task automatic clear_counts();
      cs_cycles = 0;
      rd_cycles = 0;
      wr_cycles = 0;
      strobe_cyc = -1;
   endtask

   // Called just after a rising edge; returns one cycle later with the bus idle.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic push, input logic exp_err,
                        input logic [31:0] exp_data, input int lat, output int n);
      n           = cyc;
      bus_cs      = 1'b1;
      bus_rd      = rd;
      bus_wr      = wr;
      bus_addr    = addr;
      bus_wr_data = wdata;
      if (push) sb.push_back('{err: exp_err, data: exp_data, cyc: n + lat});
      @(posedge clk);
      #1;
      bus_cs = 1'b0;
      bus_rd = 1'b0;
      bus_wr = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) check_val("ack_missing", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] d;
      reset = 1'b1;
      bus_cs = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
      bus_addr = '0; bus_wr_data = '0;
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ack", 32'(bus_ack), 32'd0);
      check_val("rst_err", 32'(bus_err), 32'd0);
      check_val("rst_rdata", bus_rd_data, 32'd0);
      check_val("rst_slot_vec", 32'(slot_cs | slot_rd | slot_wr), 32'd0);
      check_val("rst_slot_bus", slot_wr_data | 32'(slot_reg_addr), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Read slot 0 reg 3, ready immediately.
      clear_counts();
      slot0_data = 32'hDEADBEEF; rdy_delay = 0;
      issue(1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 2, n);
      wait_done();
      check_val("rd_strobe_cyc", 32'(strobe_cyc), 32'(n + 1));
      check_val("rd_strobe_vec", strobe_vec, 32'h1);
      check_val("rd_reg_addr", strobe_addr, 32'd3);
      check_val("rd_pulses", 32'(rd_cycles), 32'd1);

      // Write slot 0 reg 1, ready 3 cycles after the strobe.
      clear_counts();
      rdy_delay = 3;
      issue(1'b0, 1'b1, 32'h0000_0004, 32'h12345678, 1'b1, 1'b0, 32'h0, 5, n);
      wait_done();
      check_val("wr_pulses", 32'(wr_cycles), 32'd1);
      check_val("wr_cs_cycles", 32'(cs_cycles), 32'd4);
      check_val("wr_data", strobe_wdata, 32'h12345678);
      check_val("wr_reg_addr", strobe_addr, 32'd1);

      // Unpopulated slot 5 read and write, then illegal rd+wr.
      clear_counts();
      issue(1'b1, 1'b0, 32'h0000_0280, 32'h0, 1'b1, 1'b1, 32'h0, 1, n);
      wait_done();
      issue(1'b0, 1'b1, 32'h0000_0284, 32'h55, 1'b1, 1'b1, 32'h0, 1, n);
      wait_done();
      issue(1'b1, 1'b1, 32'h0000_0008, 32'h77, 1'b1, 1'b1, 32'h0, 1, n);
      wait_done();
      check_val("err_no_slot_activity", 32'(cs_cycles + rd_cycles + wr_cycles), 32'd0);

      // Back-to-back reads with increasing ready delay.
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         slot0_data = d; rdy_delay = i;
         issue(1'b1, 1'b0, 32'(i) << 2, 32'h0, 1'b1, 1'b0, d, 2 + i, n);
         wait_done();
      end

`ifdef IO_FABRIC_TIMEOUT_EN
      clear_counts();
      rdy_en = 1'b0;
      issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b1, 32'h0, 6, n);
      wait_done();
      check_val("to_cs_cycles", 32'(cs_cycles), 32'd5);
      check_val("to_cs_released", 32'(slot_cs), 32'd0);
      rdy_en = 1'b1; rdy_delay = 4; slot0_data = 32'hC0DE_0004;
      issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hC0DE_0004, 6, n);
      wait_done();
`else
      clear_counts();
      rdy_delay = 10; slot0_data = 32'h0BAD_F00D;
      issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 12, n);
      wait_done();
      check_val("long_cs_cycles", 32'(cs_cycles), 32'd11);
`endif

      // Reset while in WAIT discards the transfer.
      rdy_en = 1'b0;
      issue(1'b0, 1'b1, 32'h0000_0008, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 0, n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("wrst_ack", 32'(bus_ack), 32'd0);
      check_val("wrst_slot_vec", 32'(slot_cs | slot_rd | slot_wr), 32'd0);
      check_val("wrst_slot_bus", slot_wr_data | 32'(slot_reg_addr), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rdy_en = 1'b1; rdy_delay = 0; slot0_data = 32'hA1B2_C3D4;
      issue(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 1'b0, 32'hA1B2_C3D4, 2, n);
      wait_done();

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
